// File: rtl/asyalu_pkg.sv
// Shared types and default parameters for the self-timed ALU initiator.
package asyalu_pkg;

    typedef enum logic [2:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_SETUP,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_RESP,
        ST_RECOVER
    } state_e;

    typedef logic [3:0] op_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETUP_CYC_DEF   = 1;
    localparam int TIMEOUT_DEF     = 255;
    localparam int CLR_CYC_DEF     = 4;

endpackage

// File: rtl/asyalu_initiator_if.sv
// Command, ALU 4-phase and response signals bundled between initiator and its environment.
interface asyalu_initiator_if;
    import asyalu_pkg::*;

    logic       cmd_valid_i;
    logic       cmd_ready_o;
    op_t        cmd_op_i;
    logic       start_o;
    op_t        op_o;
    logic       clr_n_o;
    logic       ack_i;
    logic [3:0] dout_i;
    logic       flag_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [3:0] rsp_dout_o;
    logic       rsp_flag_o;
    logic       rsp_timeout_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, ack_i, dout_i, flag_i, rsp_ready_i,
        output cmd_ready_o, start_o, op_o, clr_n_o,
               rsp_valid_o, rsp_dout_o, rsp_flag_o, rsp_timeout_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, ack_i, dout_i, flag_i, rsp_ready_i,
        input  cmd_ready_o, start_o, op_o, clr_n_o,
               rsp_valid_o, rsp_dout_o, rsp_flag_o, rsp_timeout_o
    );

endinterface

// File: rtl/asyalu_sync.sv
// Multi-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module asyalu_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/asyalu_initiator.sv
// 4-phase initiator for a self-timed ALU: accepts a command, runs one request/ack
// cycle with per-phase timeout and clear-based recovery, then holds the response.
module asyalu_initiator
    import asyalu_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETUP_CYC   = SETUP_CYC_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CLR_CYC     = CLR_CYC_DEF
) (
    input logic               clk,
    input logic               rst,
    asyalu_initiator_if.master bus
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] CLR_LAST   = 8'(CLR_CYC - 1);
    localparam logic [7:0] SYNC_FILL  = 8'(SYNC_STAGES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic       clr_n_q, clr_n_d;
    op_t        op_q, op_d;
    logic [3:0] rsp_dout_q, rsp_dout_d;
    logic       rsp_flag_q, rsp_flag_d;
    logic       rsp_tmo_q, rsp_tmo_d;
    logic       ack_s;

    asyalu_sync #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.ack_i),
        .q_o (ack_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        start_d    = start_q;
        clr_n_d    = clr_n_q;
        op_d       = op_q;
        rsp_dout_d = rsp_dout_q;
        rsp_flag_d = rsp_flag_q;
        rsp_tmo_d  = rsp_tmo_q;

        case (state_q)
            ST_DRAIN: begin
                // The synchronizer restarts from 0 after reset, so ack_s is only
                // trusted once it has refilled with the live ack_i level.
                start_d = 1'b0;
                clr_n_d = 1'b1;
                if (cnt_q == SYNC_FILL) begin
                    cnt_d = cnt_q;
                    if (!ack_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.cmd_valid_i) begin
                    op_d    = bus.cmd_op_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    start_d = 1'b1;
                    state_d = ST_REQ_HI;
                    cnt_d   = '0;
                end
            end
            ST_REQ_HI: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (ack_s) begin
                    rsp_dout_d = bus.dout_i;
                    rsp_flag_d = bus.flag_i;
                    start_d    = 1'b0;
                    state_d    = ST_REQ_LO;
                    cnt_d      = '0;
                end else if (cnt_q == TMO_LAST) begin
                    start_d = 1'b0;
                    clr_n_d = 1'b0;
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    rsp_tmo_d = 1'b0;
                    state_d   = ST_RESP;
                    cnt_d     = '0;
                end else if (cnt_q == TMO_LAST) begin
                    clr_n_d = 1'b0;
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_RESP: begin
                cnt_d = '0;
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == CLR_LAST) begin
                    clr_n_d    = 1'b1;
                    rsp_tmo_d  = 1'b1;
                    rsp_dout_d = '0;
                    rsp_flag_d = 1'b0;
                    state_d    = ST_RESP;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DRAIN;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            clr_n_q    <= 1'b0;
            op_q       <= '0;
            rsp_dout_q <= '0;
            rsp_flag_q <= 1'b0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            clr_n_q    <= clr_n_d;
            op_q       <= op_d;
            rsp_dout_q <= rsp_dout_d;
            rsp_flag_q <= rsp_flag_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

    assign bus.start_o       = start_q;
    assign bus.clr_n_o       = clr_n_q;
    assign bus.op_o          = op_q;
    assign bus.cmd_ready_o   = (state_q == ST_IDLE);
    assign bus.rsp_valid_o   = (state_q == ST_RESP);
    assign bus.rsp_dout_o    = rsp_dout_q;
    assign bus.rsp_flag_o    = rsp_flag_q;
    assign bus.rsp_timeout_o = rsp_tmo_q;

endmodule

// File: tb/tb_asyalu_initiator.sv
// Directed bench for asyalu_initiator with a behavioural self-timed ALU model.
module tb_asyalu_initiator;
    import asyalu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    asyalu_initiator_if bus_if ();

    asyalu_initiator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // ALU model controls: response delay per phase, stuck-low ack, or manual drive.
    int         alu_delay  = 0;
    bit         alu_stuck  = 1'b0;
    bit         alu_manual = 1'b0;
    bit         man_ack    = 1'b0;
    logic [3:0] man_dout   = 4'h0;
    bit         man_flag   = 1'b0;

    // Model result: dout = op ^ 4'h9, flag = op[0]; op 3 -> A/1, op 6 -> F/0.
    initial begin
        int alu_cnt;
        alu_cnt       = 0;
        bus_if.ack_i  = 1'b0;
        bus_if.dout_i = 4'h0;
        bus_if.flag_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (alu_manual) begin
                bus_if.ack_i  = man_ack;
                bus_if.dout_i = man_dout;
                bus_if.flag_i = man_flag;
                alu_cnt       = 0;
            end else if (alu_stuck || bus_if.clr_n_o !== 1'b1) begin
                bus_if.ack_i = 1'b0;
                alu_cnt      = 0;
            end else if (bus_if.start_o !== bus_if.ack_i) begin
                if (alu_cnt >= alu_delay) begin
                    bus_if.ack_i = bus_if.start_o;
                    alu_cnt      = 0;
                    if (bus_if.start_o === 1'b1) begin
                        bus_if.dout_i = bus_if.op_o ^ 4'h9;
                        bus_if.flag_i = bus_if.op_o[0];
                    end
                end else begin
                    alu_cnt++;
                end
            end else begin
                alu_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus_if.start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus_if.start_o); end
        checks++; if (bus_if.clr_n_o !== 1'b0) begin errors++; $display("FAIL reset_clr_n: got %b want 0", bus_if.clr_n_o); end
        checks++; if (bus_if.op_o !== 4'h0) begin errors++; $display("FAIL reset_op: got %h want 0", bus_if.op_o); end
        checks++; if (bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", bus_if.cmd_ready_o); end
        checks++; if (bus_if.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid_o); end
        checks++; if (bus_if.rsp_dout_o !== 4'h0) begin errors++; $display("FAIL reset_rsp_dout: got %h want 0", bus_if.rsp_dout_o); end
        checks++; if (bus_if.rsp_flag_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_flag: got %b want 0", bus_if.rsp_flag_o); end
        checks++; if (bus_if.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_timeout: got %b want 0", bus_if.rsp_timeout_o); end
        rst = 1'b0;
        n = 0;
        while (bus_if.cmd_ready_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (bus_if.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_drain_exit: cmd_ready got %b want 1 within 20 cycles", bus_if.cmd_ready_o); end
        checks++; if (bus_if.clr_n_o !== 1'b1) begin errors++; $display("FAIL idle_clr_n: got %b want 1", bus_if.clr_n_o); end
    endtask

    task automatic test_basic();
        int n;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 4'h3;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        n = 1;
        while (bus_if.rsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL basic_latency: got %0d cycles want 8", n); end
        checks++; if (bus_if.rsp_dout_o !== 4'hA) begin errors++; $display("FAIL basic_dout: got %h want a", bus_if.rsp_dout_o); end
        checks++; if (bus_if.rsp_flag_o !== 1'b1) begin errors++; $display("FAIL basic_flag: got %b want 1", bus_if.rsp_flag_o); end
        checks++; if (bus_if.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", bus_if.rsp_timeout_o); end
        checks++; if (bus_if.op_o !== 4'h3) begin errors++; $display("FAIL basic_op: got %h want 3", bus_if.op_o); end
        checks++; if (bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_in_resp: got %b want 0", bus_if.cmd_ready_o); end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        checks++; if (bus_if.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop: got %b want 0", bus_if.rsp_valid_o); end
        checks++; if (bus_if.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL basic_back_to_idle: got %b want 1", bus_if.cmd_ready_o); end
    endtask

    task automatic test_slow_alu();
        int n, ack_rise, start_fall, op_bad, clr_bad;
        bit start_seen;
        alu_delay  = 20;
        ack_rise   = -1;
        start_fall = -1;
        op_bad     = 0;
        clr_bad    = 0;
        start_seen = 1'b0;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 4'h6;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        n = 1;
        while (bus_if.rsp_valid_o !== 1'b1 && n < 200) begin
            if (bus_if.op_o !== 4'h6) op_bad++;
            if (bus_if.clr_n_o !== 1'b1) clr_bad++;
            if (bus_if.start_o === 1'b1) start_seen = 1'b1;
            if (ack_rise < 0 && bus_if.ack_i === 1'b1) ack_rise = n;
            if (start_seen && start_fall < 0 && bus_if.start_o === 1'b0) start_fall = n;
            tick();
            n++;
        end
        checks++; if (n != 48) begin errors++; $display("FAIL slow_latency: got %0d cycles want 48", n); end
        checks++; if (ack_rise < 0 || start_fall - ack_rise != 3) begin errors++; $display("FAIL slow_start_fall: ack rose at %0d start fell at %0d want gap 3", ack_rise, start_fall); end
        checks++; if (op_bad != 0) begin errors++; $display("FAIL slow_op_stable: %0d unstable cycles want 0", op_bad); end
        checks++; if (clr_bad != 0) begin errors++; $display("FAIL slow_clr_n: %0d low cycles want 0", clr_bad); end
        checks++; if (bus_if.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL slow_timeout: got %b want 0", bus_if.rsp_timeout_o); end
        checks++; if (bus_if.rsp_dout_o !== 4'hF || bus_if.rsp_flag_o !== 1'b0) begin errors++; $display("FAIL slow_result: got %h/%b want f/0", bus_if.rsp_dout_o, bus_if.rsp_flag_o); end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        alu_delay = 0;
    endtask

    task automatic test_timeout();
        int n, hi, lo;
        alu_stuck = 1'b1;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 4'h5;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        n = 0;
        while (bus_if.start_o !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (bus_if.start_o !== 1'b1) begin errors++; $display("FAIL tmo_start_rise: got %b want 1 within 10 cycles", bus_if.start_o); end
        hi = 0;
        while (bus_if.start_o === 1'b1 && hi < 400) begin hi++; tick(); end
        checks++; if (hi != 255) begin errors++; $display("FAIL tmo_req_hi_len: got %0d cycles want 255", hi); end
        lo = 0;
        while (bus_if.clr_n_o === 1'b0 && lo < 20) begin lo++; tick(); end
        checks++; if (lo != 4) begin errors++; $display("FAIL tmo_clr_len: got %0d cycles want 4", lo); end
        checks++; if (bus_if.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL tmo_rsp_valid: got %b want 1", bus_if.rsp_valid_o); end
        checks++; if (bus_if.rsp_timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_flagged: got %b want 1", bus_if.rsp_timeout_o); end
        checks++; if (bus_if.rsp_dout_o !== 4'h0 || bus_if.rsp_flag_o !== 1'b0) begin errors++; $display("FAIL tmo_result: got %h/%b want 0/0", bus_if.rsp_dout_o, bus_if.rsp_flag_o); end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        alu_stuck = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, bad;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 4'h3;
        tick();
        bus_if.cmd_op_i = 4'h6;
        n = 1;
        while (bus_if.rsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL b2b_first_latency: got %0d cycles want 8", n); end
        bad = 0;
        repeat (10) begin
            if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_dout_o !== 4'hA || bus_if.rsp_flag_o !== 1'b1 ||
                bus_if.rsp_timeout_o !== 1'b0 || bus_if.cmd_ready_o !== 1'b0 || bus_if.op_o !== 4'h3) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_hold_stable: %0d bad cycles want 0", bad); end
        bus_if.rsp_ready_i = 1'b1;
        checks++; if (bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_during_rsp_hs: got %b want 0", bus_if.cmd_ready_o); end
        tick();
        bus_if.rsp_ready_i = 1'b0;
        checks++; if (bus_if.cmd_ready_o !== 1'b1 || bus_if.op_o !== 4'h3) begin errors++; $display("FAIL b2b_idle_after_hs: ready %b op %h want 1/3", bus_if.cmd_ready_o, bus_if.op_o); end
        tick();
        bus_if.cmd_valid_i = 1'b0;
        checks++; if (bus_if.op_o !== 4'h6 || bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: op %h ready %b want 6/0", bus_if.op_o, bus_if.cmd_ready_o); end
        n = 0;
        while (bus_if.rsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_dout_o !== 4'hF || bus_if.rsp_flag_o !== 1'b0) begin errors++; $display("FAIL b2b_second_result: valid %b got %h/%b want 1 f/0", bus_if.rsp_valid_o, bus_if.rsp_dout_o, bus_if.rsp_flag_o); end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, bad;
        alu_manual = 1'b1;
        man_ack    = 1'b0;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 4'h3;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        n = 0;
        while (bus_if.start_o !== 1'b1 && n < 10) begin tick(); n++; end
        man_dout = 4'hA;
        man_flag = 1'b1;
        man_ack  = 1'b1;
        n = 0;
        while (bus_if.start_o !== 1'b0 && n < 20) begin tick(); n++; end
        checks++; if (bus_if.start_o !== 1'b0 || bus_if.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reach_req_lo: start %b valid %b want 0/0", bus_if.start_o, bus_if.rsp_valid_o); end
        rst = 1'b1;
        tick();
        checks++; if (bus_if.start_o !== 1'b0 || bus_if.clr_n_o !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: start %b clr_n %b want 0/0", bus_if.start_o, bus_if.clr_n_o); end
        checks++; if (bus_if.rsp_dout_o !== 4'h0 || bus_if.rsp_flag_o !== 1'b0 || bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp: dout %h flag %b ready %b want 0/0/0", bus_if.rsp_dout_o, bus_if.rsp_flag_o, bus_if.cmd_ready_o); end
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus_if.cmd_ready_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_drain_hold: %0d ready cycles while ack high want 0", bad); end
        man_ack = 1'b0;
        n = 0;
        while (bus_if.cmd_ready_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 4) begin errors++; $display("FAIL mid_drain_exit: ready after %0d cycles want 4", n); end
        alu_manual = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_op_i    = 4'h0;
        bus_if.rsp_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_slow_alu();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/asyalu_initiator.md
ASYALU_INITIATOR -- requirements
Module: asyalu_initiator

Interface
REQ-001 Parameter SYNC_STAGES, default 2: ack_i synchronizer depth, legal range 2..3.
REQ-002 Parameter SETUP_CYC, default 1: cycles op_o is held stable before start_o rises, legal range 1..3.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting per ack phase, 8-bit counter.
REQ-004 Parameter CLR_CYC, default 4: cycles clr_n_o is held low in recovery.
REQ-005 clk  in  1  single clock; every flop is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both 1.
REQ-009 cmd_op_i  in  4  ALU opcode.
REQ-010 start_o  out  1  4-phase request to the self-timed ALU.
REQ-011 op_o  out  4  bundled opcode to the ALU.
REQ-012 clr_n_o  out  1  active-low ALU clear.
REQ-013 ack_i  in  1  asynchronous ALU acknowledge.
REQ-014 dout_i  in  4  ALU result, valid while ack_i is high.
REQ-015 flag_i  in  1  ALU flag, valid while ack_i is high.
REQ-016 rsp_valid_o  out  1  response held.
REQ-017 rsp_ready_i  in  1  response consumed when rsp_valid_o and rsp_ready_i are both 1.
REQ-018 rsp_dout_o  out  4  captured result.
REQ-019 rsp_flag_o  out  1  captured flag.
REQ-020 rsp_timeout_o  out  1  transaction aborted by timeout.

Function
REQ-021 States: DRAIN, IDLE, SETUP, REQ_HI, REQ_LO, RESP, RECOVER.
REQ-022 ack_i is used only after the SYNC_STAGES-flop synchronizer; ack_s denotes the synchronized value.
REQ-023 DRAIN: start_o=0; moves to IDLE on the first cycle ack_s=0.
REQ-024 IDLE: cmd_ready_o=1, and cmd_ready_o is 0 in every other state; on a handshake, cmd_op_i is registered into op_o and the FSM moves to SETUP.
REQ-025 op_o is updated only on command acceptance and holds stable through REQ_LO.
REQ-026 SETUP: lasts exactly SETUP_CYC cycles, then start_o is registered to 1 and the FSM enters REQ_HI.
REQ-027 REQ_HI: on ack_s=1, dout_i and flag_i are captured into rsp_dout_o and rsp_flag_o in the same cycle, start_o is registered to 0, and the FSM enters REQ_LO.
REQ-028 REQ_LO: on ack_s=0, the FSM enters RESP with rsp_timeout_o=0.
REQ-029 RESP: rsp_valid_o=1 and all rsp_* outputs are held stable; on rsp_ready_i=1 the FSM returns to IDLE.
REQ-030 Zero-delay ALU latency from acceptance to rsp_valid_o: 1+SETUP_CYC+2*(SYNC_STAGES+1) cycles, which is 8 with defaults; the bench checks this exact figure.
REQ-031 A wait counter clears on entry to REQ_HI and to REQ_LO and increments every cycle spent in either state.
REQ-032 When the wait counter reaches TIMEOUT: start_o=0, clr_n_o=0, and the FSM enters RECOVER.
REQ-033 RECOVER: holds clr_n_o=0 for CLR_CYC cycles, then sets clr_n_o=1 and enters RESP with rsp_timeout_o=1, rsp_dout_o=0, rsp_flag_o=0.
REQ-034 clr_n_o=1 in all states except RECOVER and reset.
REQ-035 If ack_s and the timeout terminal count coincide in the same cycle, the ack wins.
REQ-036 cmd_valid_i asserted outside IDLE is ignored and is not queued.
REQ-037 start_o and clr_n_o are driven directly from flops, with no combinational path from any input.

Reset
REQ-038 While rst=1: FSM in DRAIN, start_o=0, clr_n_o=0, op_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_dout_o=0, rsp_flag_o=0, rsp_timeout_o=0, counters 0, synchronizer flops 0.
REQ-039 rst asserted mid-transaction drops start_o on the next clock edge; after rst is released the block stays in DRAIN until ack_s=0.

Structure
REQ-040 Package asyalu_pkg holds the state enum, the 4-bit opcode type, and the default values of SYNC_STAGES, SETUP_CYC, TIMEOUT and CLR_CYC.
REQ-041 The synchronizer is a separate sub-module, asyalu_sync, parameterized by depth with reset value 0.

Verification
REQ-042 Bench ALU model with 0-cycle delay returning dout=4'hA, flag=1 for op=4'h3: response dout=A, flag=1, timeout=0, rsp_valid_o rises 8 cycles after acceptance.
REQ-043 ALU model ack delay of 20 cycles in each phase: start_o falls only after ack_s rises, no timeout, and op_o stays stable throughout.
REQ-044 ack_i held at 0 forever: after 255 cycles in REQ_HI, clr_n_o is low for exactly 4 cycles, then the response is dout=0, flag=0, timeout=1.
REQ-045 rsp_ready_i=0 for 10 cycles with cmd_valid_i held at 1: the response stays stable, cmd_ready_o=0, and the second command is accepted only on the cycle after the response handshake.
REQ-046 rst pulsed while in REQ_LO with ack_i still high: start_o=0 on the next edge, DRAIN holds until ack_i falls plus the synchronizer delay, then cmd_ready_o=1.
